// File: rtl/fifo_wlevel_mon.sv
// ============================================================================
//  Module   : fifo_wlevel_mon
//  Brief    : Write-domain occupancy monitor for an async FIFO: read-pointer
//             synchronizer, registered fill level, almost-full, overflow and
//             pointer-corruption flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_wlevel_mon #(
    parameter int N         = 4,
    parameter int AF_THRESH = 6,
    parameter int DROP_W    = 8
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic [N-1:0]      rptr,
    input  logic [N-1:0]      wptr,
    input  logic              winc,
    input  logic              wfull,
    input  logic              wovf_clr,
    output logic [N-1:0]      wq2_rptr,
    output logic [N-1:0]      wlevel,
    output logic              walmost_full,
    output logic              wovf,
    output logic [DROP_W-1:0] wdrop_cnt,
    output logic              wptr_err
);

    localparam int                DEPTH      = 1 << (N - 1);
    localparam logic [N-1:0]      c_DEPTH    = N'(DEPTH);
    localparam logic [N-1:0]      c_AF       = N'(AF_THRESH);
    localparam logic [DROP_W-1:0] c_DROP_MAX = '1;
    localparam logic [DROP_W-1:0] c_DROP_ONE = DROP_W'(1);

    logic [N-1:0]      r_sync1;
    logic [N-1:0]      r_wq2_rptr;
    logic [N-1:0]      r_wlevel;
    logic              r_walmost_full;
    logic              r_wovf;
    logic [DROP_W-1:0] r_wdrop_cnt;
    logic              r_wptr_err;

    logic [N-1:0]      w_rbin;
    logic [N-1:0]      w_wbin;
    logic [N-1:0]      w_lvl_next;
    logic              w_drop;
    logic              w_err;

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Modular n-bit subtraction: the extra wrap bit keeps the difference
    // correct when either pointer has wrapped around the address space.
    always_comb begin
        w_rbin     = gray2bin(r_wq2_rptr);
        w_wbin     = gray2bin(wptr);
        w_lvl_next = w_wbin - w_rbin;
        w_drop     = winc & wfull;
        w_err      = (w_lvl_next > c_DEPTH);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_sync1        <= '0;
            r_wq2_rptr     <= '0;
            r_wlevel       <= '0;
            r_walmost_full <= 1'b0;
            r_wovf         <= 1'b0;
            r_wdrop_cnt    <= '0;
            r_wptr_err     <= 1'b0;
        end else begin
            r_sync1        <= rptr;
            r_wq2_rptr     <= r_sync1;
            r_wlevel       <= w_lvl_next;
            r_walmost_full <= (w_lvl_next >= c_AF);

            // Set conditions take priority over the clear in the same cycle.
            if (w_drop) begin
                r_wovf <= 1'b1;
            end else if (wovf_clr) begin
                r_wovf <= 1'b0;
            end

            if (wovf_clr) begin
                r_wdrop_cnt <= w_drop ? c_DROP_ONE : '0;
            end else if (w_drop && (r_wdrop_cnt != c_DROP_MAX)) begin
                r_wdrop_cnt <= r_wdrop_cnt + c_DROP_ONE;
            end

            if (w_err) begin
                r_wptr_err <= 1'b1;
            end else if (wovf_clr) begin
                r_wptr_err <= 1'b0;
            end
        end
    end

    assign wq2_rptr     = r_wq2_rptr;
    assign wlevel       = r_wlevel;
    assign walmost_full = r_walmost_full;
    assign wovf         = r_wovf;
    assign wdrop_cnt    = r_wdrop_cnt;
    assign wptr_err     = r_wptr_err;

endmodule

`default_nettype wire
